// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART responder: RX and TX byte FIFOs behind a small register window
// at 0x8000_0000, with one-cycle registered load data.
module uart_mmio_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_LEVEL  = 8'h0C;

    logic [7:0]       rx_mem_q [DEPTH];
    logic [7:0]       tx_mem_q [DEPTH];
    logic [PW-1:0]    rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic             tx_drop_q, tx_drop_d;
    logic [31:0]      rdata_q, rdata_d;

    logic       hit, rd_en, wr_en;
    logic [7:0] off;
    logic       rx_notfull, rx_nonempty, tx_notfull, tx_nonempty;
    logic       rx_push, rx_pop, tx_push, tx_pop, tx_push_req;

    logic unused_bits;
    assign unused_bits = ^{req_wdata[31:8], req_addr[27:8]};

    always_comb begin
        hit   = (req_addr[31:28] == 4'h8);
        off   = req_addr[7:0];
        rd_en = req_re && hit;
        // A store that coincides with a load is dropped; the load wins.
        wr_en = req_we && !req_re && hit;

        rx_notfull  = (rx_cnt_q != CNT_W'(DEPTH));
        rx_nonempty = (rx_cnt_q != '0);
        tx_notfull  = (tx_cnt_q != CNT_W'(DEPTH));
        tx_nonempty = (tx_cnt_q != '0);

        rx_push     = rx_valid && rx_notfull;
        rx_pop      = rd_en && (off == OFF_RXDATA) && rx_nonempty;
        tx_push_req = wr_en && (off == OFF_TXDATA);
        tx_push     = tx_push_req && tx_notfull;
        tx_pop      = tx_nonempty && tx_ready;

        rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);

        tx_drop_d = tx_drop_q;
        if (tx_push_req && !tx_notfull) begin
            tx_drop_d = 1'b1;
        end else if (rd_en && (off == OFF_STATUS)) begin
            tx_drop_d = 1'b0;
        end

        rdata_d = rdata_q;
        if (req_re) begin
            rdata_d = '0;
            if (hit) begin
                case (off)
                    OFF_STATUS: rdata_d = {29'b0, tx_drop_q, rx_nonempty, tx_notfull};
                    OFF_RXDATA: if (rx_nonempty) rdata_d = {24'b0, rx_mem_q[rx_rd_q]};
                    OFF_LEVEL:  rdata_d = {16'b0, 8'(rx_cnt_q), 8'(tx_cnt_q)};
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rx_mem_q[i] <= '0;
                tx_mem_q[i] <= '0;
            end
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            tx_drop_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wr_q] <= rx_data;
                rx_wr_q           <= rx_wr_q + PW'(1);
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PW'(1);
            end
            if (tx_push) begin
                tx_mem_q[tx_wr_q] <= req_wdata[7:0];
                tx_wr_q           <= tx_wr_q + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PW'(1);
            end
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_drop_q <= tx_drop_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rx_ready = rst_n && rx_notfull;
    assign tx_valid = tx_nonempty;
    assign tx_data  = tx_mem_q[tx_rd_q];
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register map, FIFO full/empty edges,
// wrap-around streaming and asynchronous reset.
module tb_uart_mmio_fifo;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_LEVEL  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_addr;
    logic        req_re;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_mmio_fifo #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_re    (req_re),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req_addr = a;
        req_re   = 1'b1;
        @(posedge clk);
        #1;
        d      = rdata;
        req_re = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_addr  = a;
        req_wdata = wd;
        req_we    = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_addr = '0; req_re = 0; req_we = 0; req_wdata = '0;
        rx_data = '0; rx_valid = 0; tx_ready = 0;
        #3;
        total_cnt++;
        if ({rx_ready, tx_valid, tx_data, rdata} !== 42'd0)
            $display("FAIL reset_outputs: got %h required 0", {rx_ready, tx_valid, tx_data, rdata});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_reset: got %b required 1", rx_ready);
        else pass_cnt++;
    endtask

    task automatic test_idle_regs();
        logic [31:0] d;
        cpu_read(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL status_idle: got %h required 00000001", d);
        else pass_cnt++;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL level_idle: got %h required 00000000", d);
        else pass_cnt++;
    endtask

    task automatic test_decode();
        logic [31:0] d;
        cpu_write(32'h1000_0008, 32'h55);
        cpu_write(32'h8000_0010, 32'h56);
        @(negedge clk);
        req_addr = A_TXDATA; req_wdata = 32'h66; req_re = 1; req_we = 1;
        @(posedge clk);
        #1;
        req_re = 0; req_we = 0;
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL re_we_txdata_read: got %h required 00000000", rdata);
        else pass_cnt++;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL decode_no_push: got %h required 00000000", d);
        else pass_cnt++;
        cpu_read(A_STATUS, d);
        cpu_read(32'h4000_0000, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL nonhit_read: got %h required 00000000", d);
        else pass_cnt++;
        cpu_read(32'h8000_0020, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL unmapped_offset: got %h required 00000000", d);
        else pass_cnt++;
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cpu_write(A_TXDATA, 32'h41 + i);
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h8) $display("FAIL tx_level_full: got %h required 00000008", d);
        else pass_cnt++;
        cpu_read(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL status_drop: got %h required 00000004", d);
        else pass_cnt++;
        cpu_read(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL status_drop_clear: got %h required 00000000", d);
        else pass_cnt++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i))
                $display("FAIL tx_drain[%0d]: got valid=%b data=%h required valid=1 data=%h",
                         i, tx_valid, tx_data, 8'(8'h41 + i));
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL tx_empty_after_drain: got %b required 0", tx_valid);
        else pass_cnt++;
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_full();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'(8'h10 + i);
            total_cnt++;
            if (rx_ready !== 1'b1) $display("FAIL rx_ready_fill[%0d]: got %b required 1", i, rx_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rx_data = 8'h18;
        total_cnt++;
        if (rx_ready !== 1'b0) $display("FAIL rx_ready_full: got %b required 0", rx_ready);
        else pass_cnt++;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0800) $display("FAIL rx_level_full: got %h required 00000800", d);
        else pass_cnt++;
        cpu_read(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h3) $display("FAIL status_rx_nonempty: got %h required 00000003", d);
        else pass_cnt++;
        cpu_read(A_RXDATA, d);
        total_cnt++;
        if (d !== 32'h10) $display("FAIL rx_read[0]: got %h required 00000010", d);
        else pass_cnt++;
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_pop: got %b required 1", rx_ready);
        else pass_cnt++;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            cpu_read(A_RXDATA, d);
            total_cnt++;
            if (d !== 32'h10 + i) $display("FAIL rx_read[%0d]: got %h required %h", i, d, 32'h10 + i);
            else pass_cnt++;
        end
        cpu_read(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL status_rx_empty: got %h required 00000001", d);
        else pass_cnt++;
    endtask

    task automatic test_rx_empty();
        logic [31:0] d;
        cpu_read(A_RXDATA, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rx_empty_read: got %h required 00000000", d);
        else pass_cnt++;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rx_empty_level: got %h required 00000000", d);
        else pass_cnt++;
        @(negedge clk);
        req_addr = A_RXDATA; req_re = 1; rx_valid = 1; rx_data = 8'hAA;
        @(posedge clk);
        #1;
        req_re = 0; rx_valid = 0;
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL rx_push_pop_empty: got %h required 00000000", rdata);
        else pass_cnt++;
        cpu_read(A_RXDATA, d);
        total_cnt++;
        if (d !== 32'hAA) $display("FAIL rx_bypassed_byte: got %h required 000000aa", d);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (rdata !== 32'hAA) $display("FAIL rdata_hold: got %h required 000000aa", rdata);
        else pass_cnt++;
    endtask

    task automatic tx_stream(input int first, input int n);
        logic [7:0] exp;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            req_addr = A_TXDATA; req_wdata = 32'h70 + i; req_we = 1; tx_ready = 1;
            exp = (i < 3) ? 8'(8'h60 + i) : 8'(8'h70 + i - 3);
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== exp)
                $display("FAIL tx_stream[%0d]: got valid=%b data=%h required valid=1 data=%h",
                         i, tx_valid, tx_data, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        req_we = 0; tx_ready = 0;
    endtask

    task automatic rx_stream(input int first, input int n);
        logic [31:0] exp;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            req_addr = A_RXDATA; req_re = 1; rx_valid = 1; rx_data = 8'(8'h80 + i);
            @(posedge clk);
            #1;
            exp = (i < 3) ? (32'h50 + i) : (32'h80 + i - 3);
            total_cnt++;
            if (rdata !== exp) $display("FAIL rx_stream[%0d]: got %h required %h", i, rdata, exp);
            else pass_cnt++;
        end
        req_re = 0; rx_valid = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) cpu_write(A_TXDATA, 32'h60 + i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1; rx_data = 8'(8'h50 + i);
            @(posedge clk);
            #1;
        end
        rx_valid = 0;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0303) $display("FAIL wrap_level_pre: got %h required 00000303", d);
        else pass_cnt++;
        for (int h = 0; h < 2; h++) begin
            tx_stream(h * 10, 10);
            cpu_read(A_LEVEL, d);
            total_cnt++;
            if (d !== 32'h0303) $display("FAIL wrap_tx_level[%0d]: got %h required 00000303", h, d);
            else pass_cnt++;
        end
        for (int h = 0; h < 2; h++) begin
            rx_stream(h * 10, 10);
            cpu_read(A_LEVEL, d);
            total_cnt++;
            if (d !== 32'h0303) $display("FAIL wrap_rx_level[%0d]: got %h required 00000303", h, d);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        cpu_write(A_TXDATA, 32'hC0);
        @(negedge clk);
        rx_valid = 1; rx_data = 8'hC1;
        @(posedge clk);
        #1 rx_valid = 0;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0404 || tx_valid !== 1'b1)
            $display("FAIL half_full_pre_reset: got level=%h valid=%b required level=00000404 valid=1", d, tx_valid);
        else pass_cnt++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({tx_valid, rx_ready, tx_data} !== 10'd0)
            $display("FAIL async_reset_outputs: got %h required 0", {tx_valid, rx_ready, tx_data});
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_async_reset: got %b required 1", rx_ready);
        else pass_cnt++;
        cpu_read(A_LEVEL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL level_after_async_reset: got %h required 00000000", d);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_regs();
        test_decode();
        test_tx_full();
        test_rx_full();
        test_rx_empty();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
